// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: FSM state encodings and byte width shared by the UART transmitter.
package uart_tx_fifo_pkg;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam int WIDTH = 8;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write port, serial line and status flags of the buffered UART transmitter.
interface uart_tx_fifo_if;
  logic wr;
  logic [7:0] data;
  logic tx, full, empty, busy;
  modport master(output wr, data, input tx, full, empty, busy);
  modport slave(input wr, data, output tx, full, empty, busy);
endinterface

// File: rtl/baudgen.vh
// baudgen.vh: shared baud divisors, expressed as system clock cycles per serial bit.
`ifndef BAUDGEN_VH
`define BAUDGEN_VH
`define B115200 104
`define B57600  208
`define B38400  312
`define B19200  625
`define B9600   1250
`define B4800   2500
`define B2400   5000
`define B1200   10000
`define B600    20000
`define B300    40000
`endif

// File: rtl/uart_tx_fifo_fifo.sv
// fifo_sync: single-clock FIFO with combinational head read; writes while full are dropped.
module fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_wr, do_rd;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rp];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 serial transmitter fed from a byte FIFO; frames drain back-to-back.
`include "baudgen.vh"
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int BAUD  = `B115200,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave bus
);
  localparam int BW = $clog2(BAUD);
  logic [1:0] state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [WIDTH-1:0] shreg, dout;
  logic tx, busy, empty, pop, baud_end;
  assign baud_end  = baud == BW'(BAUD - 1);
  assign pop       = !empty && (state == IDLE || (state == STOP && baud_end));
  assign bus.tx    = tx;
  assign bus.busy  = busy;
  assign bus.empty = empty;
  fifo_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk(clk), .rstn(rstn), .wr(bus.wr), .din(bus.data), .rd(pop),
    .dout(dout), .full(bus.full), .empty(empty)
  );
  // tx and busy are registered off the state, so both lag it by one cycle and stay aligned
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      baud <= (state == IDLE || baud_end || pop) ? '0 : baud + 1'b1;
      tx   <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      busy <= state != IDLE;
      if (pop) begin
        shreg <= dout;
        state <= START;
      end else if (baud_end) begin
        if (state == START) begin
          state   <= DATA;
          bit_idx <= '0;
        end else if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end else if (state == STOP) begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; stimulus queues expected bytes, a UART monitor decodes tx and compares.
`include "baudgen.vh"
module tb_uart_tx_fifo;
  localparam int B  = 4;
  localparam int D  = 4;
  localparam int BD = `B115200;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0, pass = 0, total = 0;
  logic [7:0] sb[$];
  int starts[$];
  uart_tx_fifo_if bus();
  uart_tx_fifo_if bus2();
  uart_tx_fifo #(.BAUD(B), .DEPTH(D)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  uart_tx_fifo dut2 (.clk(clk), .rstn(rstn), .bus(bus2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  // call at a negedge; k returns the index of the edge that sampled the write
  task automatic put(input logic [7:0] b, input bit exp, output int k);
    if (exp) sb.push_back(b);
    bus.wr = 1'b1;
    bus.data = b;
    @(negedge clk);
    k = cyc;
    bus.wr = 1'b0;
  endtask
  // UART receiver for the BAUD=4 instance: samples mid-bit on negedges
  initial begin
    logic [7:0] b;
    logic st, sp;
    bit ab;
    forever begin
      @(negedge clk);
      if (rstn && bus.tx === 1'b0) begin
        starts.push_back(cyc);
        ab = 1'b0;
        repeat (B / 2) @(negedge clk);
        st = bus.tx;
        ab |= !rstn;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = bus.tx;
          ab |= !rstn;
        end
        repeat (B) @(negedge clk);
        sp = bus.tx;
        ab |= !rstn;
        repeat (B / 2 - 1) @(negedge clk);
        if (!ab) begin
          if (sb.size() == 0) chk("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
          else chk("frame_byte", {24'd0, b}, {24'd0, sb.pop_front()});
          chk("start_bit", {31'd0, st}, 32'd0);
          chk("stop_bit", {31'd0, sp}, 32'd1);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k, k0, n, w, t0;
    bus.wr = 1'b0;
    bus.data = '0;
    bus2.wr = 1'b0;
    bus2.data = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, bus.tx}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    // single byte: latency and busy window
    put(8'h55, 1'b1, k);
    chk("single_tx_k1", {31'd0, bus.tx}, 32'd1);
    at_cyc(k + 1);
    chk("single_tx_k1b", {31'd0, bus.tx}, 32'd1);
    at_cyc(k + 2);
    chk("single_tx_k2", {31'd0, bus.tx}, 32'd0);
    at_cyc(k + 41);
    chk("single_busy_k41", {31'd0, bus.busy}, 32'd1);
    at_cyc(k + 42);
    chk("single_busy_k42", {31'd0, bus.busy}, 32'd0);
    chk("single_empty", {31'd0, bus.empty}, 32'd1);
    at_cyc(k + 50);
    // burst of three: contiguous frames
    put(8'h41, 1'b1, k0);
    put(8'h42, 1'b1, k);
    put(8'h43, 1'b1, k);
    at_cyc(k0 + 3 * 40 + 10);
    n = starts.size();
    chk("burst_first_start", starts[n-3], k0 + 2);
    chk("burst_gap_1_2", starts[n-2] - starts[n-3], 32'd40);
    chk("burst_gap_2_3", starts[n-1] - starts[n-2], 32'd40);
    chk("burst_busy_end", {31'd0, bus.busy}, 32'd0);
    // overflow: 0x06 dropped
    put(8'h01, 1'b1, k0);
    put(8'h02, 1'b1, k);
    put(8'h03, 1'b1, k);
    put(8'h04, 1'b1, k);
    chk("ovf_full_after3", {31'd0, bus.full}, 32'd0);
    put(8'h05, 1'b1, k);
    chk("ovf_full_after4", {31'd0, bus.full}, 32'd1);
    put(8'h06, 1'b0, k);
    chk("ovf_full_after_drop", {31'd0, bus.full}, 32'd1);
    at_cyc(k0 + 5 * 40 + 10);
    chk("ovf_empty_end", {31'd0, bus.empty}, 32'd1);
    // write while full exactly on the STOP-end pop edge
    put(8'h11, 1'b1, k0);
    put(8'h12, 1'b1, k);
    put(8'h13, 1'b1, k);
    put(8'h14, 1'b1, k);
    put(8'h15, 1'b1, k);
    at_cyc(k0 + 40);
    chk("simul_full_before", {31'd0, bus.full}, 32'd1);
    put(8'h99, 1'b0, k);
    chk("simul_pop_edge", k, k0 + 41);
    chk("simul_full_after", {31'd0, bus.full}, 32'd0);
    chk("simul_empty_after", {31'd0, bus.empty}, 32'd0);
    at_cyc(k0 + 5 * 40 + 10);
    // reset during bit 3 of 0xA5 with two bytes queued
    put(8'hA5, 1'b0, k0);
    put(8'h01, 1'b0, k);
    put(8'h02, 1'b0, k);
    at_cyc(k0 + 19);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_tx", {31'd0, bus.tx}, 32'd1);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_mid_full", {31'd0, bus.full}, 32'd0);
    repeat (8) @(negedge clk);
    rstn = 1'b1;
    at_cyc(cyc + 50);
    put(8'h3C, 1'b1, k);
    at_cyc(k + 2);
    chk("post_rst_tx_k2", {31'd0, bus.tx}, 32'd0);
    at_cyc(k + 50);
    // default divisor instance
    bus2.wr = 1'b1;
    bus2.data = 8'hFF;
    @(negedge clk);
    k = cyc;
    bus2.wr = 1'b0;
    n = 0;
    while (bus2.tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b115200_latency", cyc, k + 2);
    w = 0;
    while (bus2.tx === 1'b0 && w < 4 * BD) begin
      w++;
      @(negedge clk);
    end
    chk("b115200_start_width", w, BD);
    t0 = cyc - w;
    while (bus2.busy === 1'b1 && cyc < t0 + 20 * BD) @(negedge clk);
    chk("b115200_frame_len", cyc - t0, 10 * BD);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
